// File: rtl/ins_fetch_unit.sv
// Program RAM with a valid/ready load port and a two-cycle FETCH/EXEC issue loop
// that presents one stable instruction per core clock enable.
module ins_fetch_unit #(
  parameter int                INS_W     = 21,
  parameter int                ADDR_W    = 8,
  parameter logic [INS_W-1:0]  HALT_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [INS_W-1:0]  ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              run,
  input  logic              stop,
  input  logic [ADDR_W-1:0] addr,
  output logic [INS_W-1:0]  ins,
  output logic              cpu_en,
  output logic [ADDR_W:0]   ld_count,
  output logic [15:0]       issued,
  output logic [2:0]        state
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [INS_W-1:0]  mem [DEPTH];
  logic [INS_W-1:0]  ram_q_reg;
  logic              hit_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   ld_count_reg;
  logic [15:0]       issued_reg;
  logic              ld_ready_reg;
  logic              xfer, last_xfer, is_halt, parked;

  assign parked    = (state_reg == S_IDLE) || (state_reg == S_HALT);
  assign xfer      = (state_reg == S_LOAD) && ld_valid && ld_ready_reg;
  assign last_xfer = xfer && (ld_last || (&wr_ptr_reg));

  // Words at or beyond the loaded length read as HALT_WORD via the hit flag.
  assign ins     = hit_reg ? ram_q_reg : HALT_WORD;
  assign is_halt = (ins == HALT_WORD);
  assign cpu_en  = (state_reg == S_EXEC) && !is_halt;

  assign ld_ready = ld_ready_reg;
  assign ld_count = ld_count_reg;
  assign issued   = issued_reg;
  assign state    = state_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALT: begin
        if (ld_start)
          state_next = S_LOAD;
        else if (run && (ld_count_reg != '0))
          state_next = S_FETCH;
      end
      S_LOAD:  if (last_xfer) state_next = S_IDLE;
      S_FETCH: state_next = stop ? S_HALT : S_EXEC;
      S_EXEC:  state_next = (is_halt || stop) ? S_HALT : S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ld_ready_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      ld_count_reg <= '0;
      issued_reg   <= '0;
      hit_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ld_ready_reg <= (state_next == S_LOAD);
      if (parked && ld_start) begin
        wr_ptr_reg   <= '0;
        ld_count_reg <= '0;
      end else if (xfer) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
        ld_count_reg <= ld_count_reg + CNT_ONE;
      end
      if (parked && (state_next == S_FETCH))
        issued_reg <= '0;
      else if (cpu_en && (issued_reg != 16'hFFFF))
        issued_reg <= issued_reg + 16'd1;
      if (state_reg == S_FETCH)
        hit_reg <= ({1'b0, addr} < ld_count_reg);
    end
  end

  // RAM kept free of reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_ptr_reg] <= ld_data;
    if (state_reg == S_FETCH)
      ram_q_reg <= mem[addr];
  end
endmodule

// File: tb/tb_ins_fetch_unit.sv
// Randomized bench for ins_fetch_unit: loads programs, runs them with a core model
// that steps addr on every cpu_en, and compares against a program-array reference.
module tb_ins_fetch_unit;
  localparam int INS_W  = 21;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0, rst = 1'b0;
  logic              ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic              run = 1'b0, stop = 1'b0;
  logic [INS_W-1:0]  ld_data = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic              ld_ready, cpu_en;
  logic [INS_W-1:0]  ins;
  logic [ADDR_W:0]   ld_count;
  logic [15:0]       issued;
  logic [2:0]        state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [INS_W-1:0] prog [DEPTH];
  int prog_len = 0;

  ins_fetch_unit #(.INS_W(INS_W), .ADDR_W(ADDR_W), .HALT_WORD('0)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .run(run),
    .stop(stop), .addr(addr), .ins(ins), .cpu_en(cpu_en), .ld_count(ld_count),
    .issued(issued), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_state"},    32'(state), 32'd0);
    chk({tag, "_ins"},      32'(ins), 32'd0);
    chk({tag, "_cpu_en"},   32'(cpu_en), 32'd0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_ld_count"}, 32'(ld_count), 32'd0);
    chk({tag, "_issued"},   32'(issued), 32'd0);
    $display("reset %s checked", tag);
  endtask

  task automatic idle_run();
    bit en_seen = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("idle_run_state", 32'(state), 32'd0);
    for (int i = 0; i < 6; i++) begin
      en_seen |= cpu_en;
      step();
    end
    chk("idle_run_no_en", 32'(en_seen), 32'd0);
    chk("idle_run_stay", 32'(state), 32'd0);
    $display("run with empty program ignored");
  endtask

  // mode: 0 continuous, 1 random gaps, 2 two-cycle gap after word 0, 3 overflow
  task automatic do_load(input int n, input int mode, input bit with_run);
    int idx = 0, cyc = 0, xfers = 0, gap = 0, exp_n;
    exp_n = (mode == 3) ? DEPTH : n;
    ld_start = 1'b1;
    run = with_run;
    step();
    ld_start = 1'b0;
    run = 1'b0;
    chk("load_enter", 32'(state), 32'd1);
    chk("load_ready", 32'(ld_ready), 32'd1);
    while (cyc < 400 && ((mode == 3) ? (cyc < 300) : (idx < n))) begin
      case (mode)
        1: ld_valid = ($urandom_range(0, 2) != 0);
        2: ld_valid = !(idx == 1 && gap < 2);
        default: ld_valid = 1'b1;
      endcase
      if (mode == 2 && idx == 1 && gap < 2) gap++;
      ld_data = prog[idx % DEPTH];
      ld_last = (mode != 3) && (idx == n - 1);
      if (ld_valid && ld_ready) begin
        idx++;
        xfers++;
      end
      step();
      cyc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_xfers", 32'(xfers), 32'(exp_n));
    chk("load_count", 32'(ld_count), 32'(exp_n));
    chk("load_ready_low", 32'(ld_ready), 32'd0);
    chk("load_idle", 32'(state), 32'd0);
    prog_len = exp_n;
    $display("load mode %0d words %0d ld_count %0d", mode, exp_n, ld_count);
  endtask

  task automatic do_run();
    int exp_n, k = 0, cyc = 0, last_en = -1;
    exp_n = prog_len;
    for (int i = prog_len - 1; i >= 0; i--)
      if (prog[i] == '0) exp_n = i;
    addr = '0;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("run_fetch", 32'(state), 32'd2);
    chk("run_clr", 32'(issued), 32'd0);
    while (state != 3'd4 && cyc < 1200) begin
      if (cpu_en) begin
        chk("run_ins", 32'(ins), (k < DEPTH) ? 32'(prog[k]) : 32'd0);
        chk("run_en_spacing", 32'(cyc - last_en), 32'd2);
        last_en = cyc;
        k++;
        addr = addr + 1'b1;
      end
      step();
      cyc++;
    end
    chk("run_issues", 32'(k), 32'(exp_n));
    chk("run_issued", 32'(issued), 32'(exp_n));
    chk("run_halt", 32'(state), 32'd4);
    chk("run_halt_en", 32'(cpu_en), 32'd0);
    $display("run issued %0d of %0d loaded, state %0d", issued, prog_len, state);
  endtask

  task automatic do_stop();
    int cyc = 0, k = 0;
    bit done = 0;
    addr = '0;
    run = 1'b1;
    step();
    run = 1'b0;
    while (!done && cyc < 50) begin
      if (cpu_en) begin
        k++;
        addr = addr + 1'b1;
        if (k == 2) begin
          stop = 1'b1;
          chk("stop_ins", 32'(ins), 32'(prog[1]));
          step();
          stop = 1'b0;
          done = 1;
          chk("stop_halt", 32'(state), 32'd4);
          chk("stop_issued", 32'(issued), 32'd2);
        end
      end
      if (!done) begin
        step();
        cyc++;
      end
    end
    chk("stop_seen", 32'(done), 32'd1);
    $display("stop after %0d issues, state %0d", issued, state);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 reset_check("rst_init");
    step();
    step();
    rst = 1'b0;

    idle_run();

    prog[0] = 21'h0B8000;
    prog[1] = 21'h0C0005;
    prog[2] = 21'h0C0807;
    do_load(3, 2, 1'b0);
    do_run();
    do_stop();
    do_run();

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        prog[i] = ($urandom_range(0, 7) == 0) ? '0 : INS_W'($urandom_range(1, (1 << INS_W) - 1));
      do_load(n, 1, r == 0);
      do_run();
    end

    for (int i = 0; i < DEPTH; i++)
      prog[i] = INS_W'($urandom_range(1, (1 << INS_W) - 1));
    prog[$urandom_range(10, 60)] = '0;
    do_load(DEPTH, 3, 1'b0);
    do_run();

    addr = '0;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1 reset_check("rst_run");
    step();
    rst = 1'b0;
    idle_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
